// File: rtl/snake_step_controller_pkg.sv
// Shared state encodings, widths and defaults for the snake step sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package snake_step_controller_pkg;

  localparam int LIVES_WIDTH      = 3;
  localparam int SCORE_WIDTH      = 8;
  localparam int TICK_DIV_DEFAULT = 5000000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_MOVE    = 3'd2,
    ST_CHECK   = 3'd3,
    ST_RESPAWN = 3'd4,
    ST_FREEZE  = 3'd5,
    ST_OVER    = 3'd6
  } state_t;

  localparam logic [SCORE_WIDTH-1:0] SCORE_MAX = '1;

  // Score increment that sticks at the top value instead of wrapping.
  function automatic logic [SCORE_WIDTH-1:0] score_sat_inc(input logic [SCORE_WIDTH-1:0] v);
    return (v == SCORE_MAX) ? v : v + SCORE_WIDTH'(1);
  endfunction

endpackage

// File: rtl/snake_step_controller_tick_divider.sv
// Movement tick divider: counts enabled clk cycles, strobes tick on the last one.
// Latency: tick is combinational from the count; it asserts on the TICK_DIV-th enabled cycle.
// Backpressure: none; en low simply holds the count, clear zeroes it.
module snake_step_controller_tick_divider
  import snake_step_controller_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clear,
  output logic tick
);

  // TICK_DIV must be at least 2, so the width is always at least one bit.
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  assign tick = en && (count == LAST);

  // Count enabled cycles, wrapping to zero on the tick; clear wins over counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/snake_step_controller.sv
// Game sequencer: tick -> move -> collision check -> wait/respawn/freeze/game-over.
// Latency: tick->move_en 1, move_en->check_req 1, check_valid->grow 1, collision->respawn 1.
// Backpressure: none; a check with no verdict is abandoned after CHECK_TIMEOUT cycles.
module snake_step_controller
  import snake_step_controller_pkg::*;
#(
  parameter int TICK_DIV      = TICK_DIV_DEFAULT,
  parameter int FREEZE_TICKS  = 3,
  parameter int INIT_LIVES    = 3,
  parameter int CHECK_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   pause,
  input  logic                   check_valid,
  input  logic                   collision,
  input  logic                   ate_food,
  output logic                   move_en,
  output logic                   check_req,
  output logic                   respawn,
  output logic                   grow,
  output logic [LIVES_WIDTH-1:0] lives,
  output logic [SCORE_WIDTH-1:0] score,
  output logic                   game_over,
  output logic [2:0]             state_dbg
);

  // FREEZE_TICKS and CHECK_TIMEOUT are assumed to be at least 1.
  localparam int FW = (FREEZE_TICKS  > 1) ? $clog2(FREEZE_TICKS + 1)  : 1;
  localparam int TW = (CHECK_TIMEOUT > 1) ? $clog2(CHECK_TIMEOUT + 1) : 1;
  localparam logic [FW-1:0]          FREEZE_LAST  = FW'(FREEZE_TICKS - 1);
  localparam logic [TW-1:0]          TIMEOUT_LAST = TW'(CHECK_TIMEOUT - 1);
  localparam logic [LIVES_WIDTH-1:0] LIVES_INIT   = LIVES_WIDTH'(INIT_LIVES);

  state_t        state_q, state_d;
  logic          tick, tick_en, tick_clr;
  logic          start_game, last_life, freeze_last, timeout_hit;
  logic          move_d, check_req_d, grow_d, respawn_d;
  logic [FW-1:0] freeze_cnt;
  logic [TW-1:0] timeout_cnt;

  assign start_game  = start && (state_q == ST_IDLE || state_q == ST_OVER);
  assign last_life   = (lives <= LIVES_WIDTH'(1));
  assign freeze_last = (freeze_cnt == FREEZE_LAST);
  assign timeout_hit = (timeout_cnt == TIMEOUT_LAST);

  // The tick only advances while the snake is waiting to move or frozen, and not paused.
  assign tick_en  = !pause && (state_q == ST_WAIT || state_q == ST_FREEZE);
  assign tick_clr = start_game || (state_q == ST_RESPAWN);

  snake_step_controller_tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_divider (
    .clk   (clk),
    .reset (reset),
    .en    (tick_en),
    .clear (tick_clr),
    .tick  (tick)
  );

  // Next-state and next-cycle pulse decode; pulses are registered below so they
  // line up with the state they belong to (move_en in MOVE, check_req on CHECK entry,
  // respawn during RESPAWN, grow on the cycle after the verdict).
  always_comb begin
    state_d     = state_q;
    move_d      = 1'b0;
    check_req_d = 1'b0;
    grow_d      = 1'b0;
    respawn_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (tick) begin
          state_d = ST_MOVE;
          move_d  = 1'b1;
        end
      end
      ST_MOVE: begin
        state_d     = ST_CHECK;
        check_req_d = 1'b1;
      end
      ST_CHECK: begin
        if (check_valid) begin
          if (collision) begin
            // Collision beats food in the same verdict.
            state_d   = ST_RESPAWN;
            respawn_d = !last_life;
          end else begin
            state_d = ST_WAIT;
            grow_d  = ate_food;
          end
        end else if (timeout_hit) begin
          state_d = ST_WAIT;
        end
      end
      ST_RESPAWN: begin
        state_d = last_life ? ST_OVER : ST_FREEZE;
      end
      ST_FREEZE: begin
        if (tick && freeze_last) state_d = ST_WAIT;
      end
      ST_OVER: begin
        if (start) state_d = ST_WAIT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register and registered one-cycle pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      move_en   <= 1'b0;
      check_req <= 1'b0;
      grow      <= 1'b0;
      respawn   <= 1'b0;
    end else begin
      state_q   <= state_d;
      move_en   <= move_d;
      check_req <= check_req_d;
      grow      <= grow_d;
      respawn   <= respawn_d;
    end
  end

  // Lives and score: reload on a new game, lose a life on leaving RESPAWN, score on food.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lives <= LIVES_INIT;
      score <= '0;
    end else if (start_game) begin
      lives <= LIVES_INIT;
      score <= '0;
    end else if (state_q == ST_RESPAWN) begin
      if (lives != '0) lives <= lives - LIVES_WIDTH'(1);
    end else if (grow_d) begin
      score <= score_sat_inc(score);
    end
  end

  // Freeze counter: zeroed while respawning, counts tick wraps while frozen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      freeze_cnt <= '0;
    end else if (state_q == ST_RESPAWN) begin
      freeze_cnt <= '0;
    end else if (state_q == ST_FREEZE && tick) begin
      freeze_cnt <= freeze_cnt + FW'(1);
    end
  end

  // Check timeout: counts cycles spent in CHECK, zero on every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_cnt <= '0;
    end else if (state_q == ST_CHECK) begin
      timeout_cnt <= timeout_cnt + TW'(1);
    end else begin
      timeout_cnt <= '0;
    end
  end

  assign game_over = (state_q == ST_OVER);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_snake_step_controller.sv
module tb_snake_step_controller;

  localparam int TICK_DIV      = 4;
  localparam int FREEZE_TICKS  = 3;
  localparam int INIT_LIVES    = 3;
  localparam int CHECK_TIMEOUT = 15;

  localparam int EV_MOVE = 0, EV_CHECK = 1, EV_GROW = 2, EV_RESPAWN = 3, EV_OVER = 4;
  // Game phases of the reference model.
  localparam int M_IDLE = 0, M_RUN = 1, M_MOVE = 2, M_CHECK = 3, M_HIT = 4, M_FROZEN = 5, M_OVER = 6;

  logic       clk, reset, start, pause, check_valid, collision, ate_food;
  logic       move_en, check_req, respawn, grow, game_over;
  logic [2:0] lives, state_dbg;
  logic [7:0] score;

  snake_step_controller #(
    .TICK_DIV      (TICK_DIV),
    .FREEZE_TICKS  (FREEZE_TICKS),
    .INIT_LIVES    (INIT_LIVES),
    .CHECK_TIMEOUT (CHECK_TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pause       (pause),
    .check_valid (check_valid),
    .collision   (collision),
    .ate_food    (ate_food),
    .move_en     (move_en),
    .check_req   (check_req),
    .respawn     (respawn),
    .grow        (grow),
    .lives       (lives),
    .score       (score),
    .game_over   (game_over),
    .state_dbg   (state_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int kind;
    int cyc;
    int lives;
    int score;
  } ev_t;

  ev_t expq[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;

  // Reference model state: game phase plus plain cycle counts.
  int m_ph = M_IDLE;
  int m_lives = INIT_LIVES;
  int m_score = 0;
  int run_cnt = 0;   // unpaused cycles since the snake was last armed to move
  int frz_cnt = 0;   // unpaused cycles spent frozen
  int age = 0;       // cycles spent waiting for a verdict

  // Stimulus knobs, percentages.
  int k_start, k_pause, k_valid, k_coll, k_ate, k_noise;

  function automatic string ev_name(input int k);
    case (k)
      EV_MOVE:    return "move_en";
      EV_CHECK:   return "check_req";
      EV_GROW:    return "grow";
      EV_RESPAWN: return "respawn";
      default:    return "game_over";
    endcase
  endfunction

  task automatic push(input int kind, input int c);
    ev_t e;
    e.kind  = kind;
    e.cyc   = c;
    e.lives = m_lives;
    e.score = m_score;
    expq.push_back(e);
  endtask

  // One clock edge of the game rules, using the inputs sampled at that edge.
  task automatic model_edge();
    if (reset) begin
      m_ph = M_IDLE; m_lives = INIT_LIVES; m_score = 0;
      return;
    end
    case (m_ph)
      M_IDLE, M_OVER: begin
        if (start) begin
          m_lives = INIT_LIVES; m_score = 0; run_cnt = 0; m_ph = M_RUN;
        end
      end
      M_RUN: begin
        if (!pause) begin
          run_cnt++;
          if (run_cnt == TICK_DIV) begin
            run_cnt = 0; m_ph = M_MOVE; push(EV_MOVE, cyc);
          end
        end
      end
      M_MOVE: begin
        m_ph = M_CHECK; age = 0; push(EV_CHECK, cyc);
      end
      M_CHECK: begin
        if (check_valid) begin
          if (collision) begin
            m_ph = M_HIT;
            if (m_lives > 1) push(EV_RESPAWN, cyc);
          end else begin
            if (ate_food) begin
              if (m_score < 255) m_score++;
              push(EV_GROW, cyc);
            end
            m_ph = M_RUN; run_cnt = 0;
          end
        end else begin
          age++;
          if (age == CHECK_TIMEOUT) begin
            m_ph = M_RUN; run_cnt = 0;
          end
        end
      end
      M_HIT: begin
        if (m_lives <= 1) begin
          m_lives = 0; m_ph = M_OVER; push(EV_OVER, cyc);
        end else begin
          m_lives--; m_ph = M_FROZEN; frz_cnt = 0;
        end
      end
      M_FROZEN: begin
        if (!pause) begin
          frz_cnt++;
          if (frz_cnt == FREEZE_TICKS * TICK_DIV) begin
            m_ph = M_RUN; run_cnt = 0;
          end
        end
      end
      default: m_ph = M_IDLE;
    endcase
  endtask

  function automatic logic chance(input int pct);
    return int'($urandom_range(99, 0)) < pct;
  endfunction

  task automatic drive();
    start       = (m_ph == M_IDLE || m_ph == M_OVER) ? chance(k_start) : chance(k_noise);
    pause       = chance(k_pause);
    check_valid = (m_ph == M_CHECK) ? chance(k_valid) : chance(k_noise);
    collision   = chance(k_coll);
    ate_food    = chance(k_ate);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      drive();
      step();
    end
  endtask

  // Compare one DUT pulse against the oldest expected event.
  task automatic check_ev(input int kind);
    ev_t e;
    vectors++;
    if (expq.size() == 0) begin
      miscompares++;
      $display("FAIL %s: DUT pulsed at cycle %0d, model expected no event", ev_name(kind), cyc);
    end else begin
      e = expq.pop_front();
      if (e.kind != kind || e.cyc != cyc || int'(lives) != e.lives ||
          int'(score) != e.score || game_over != (kind == EV_OVER)) begin
        miscompares++;
        $display("FAIL %s: got cycle=%0d lives=%0d score=%0d game_over=%0b, expected %s cycle=%0d lives=%0d score=%0d",
                 ev_name(kind), cyc, lives, score, game_over, ev_name(e.kind), e.cyc, e.lives, e.score);
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  initial begin
    logic go_prev;
    go_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset === 1'b0) begin
        if (move_en)               check_ev(EV_MOVE);
        if (check_req)             check_ev(EV_CHECK);
        if (grow)                  check_ev(EV_GROW);
        if (respawn)               check_ev(EV_RESPAWN);
        if (game_over && !go_prev) check_ev(EV_OVER);
      end
      go_prev = game_over;
    end
  end

  // Asynchronous reset from wherever the game is; checks the reset values before any clock edge.
  task automatic do_reset(input string where);
    int stale;
    stale = 0;
    foreach (expq[i]) if (expq[i].cyc < cyc) stale++;
    vectors++;
    if (stale != 0) begin
      miscompares++;
      $display("FAIL missed_events before reset %s: %0d expected events never seen, required 0", where, stale);
    end
    start = 0; pause = 0; check_valid = 0; collision = 0; ate_food = 0;
    reset = 1'b1;
    #1;
    vectors++;
    if ({state_dbg, lives, score, move_en, check_req, grow, respawn, game_over} !==
        {3'd0, 3'(INIT_LIVES), 8'd0, 5'b00000}) begin
      miscompares++;
      $display("FAIL reset %s: state=%0d lives=%0d score=%0d pulses=%b%b%b%b game_over=%b, required state=0 lives=%0d score=0 pulses=0000 game_over=0",
               where, state_dbg, lives, score, move_en, check_req, grow, respawn, game_over, INIT_LIVES);
    end
    expq.delete();
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 0; start = 0; pause = 0; check_valid = 0; collision = 0; ate_food = 0;
    #1;
    do_reset("power-on");

    // Plain moves: immediate verdicts, no collision, no food.
    k_start = 100; k_pause = 0; k_valid = 100; k_coll = 0; k_ate = 0; k_noise = 0;
    run(30);

    // Food on every check: score climbs to the saturation point.
    k_ate = 100;
    run(1700);
    vectors++;
    if (score !== 8'd255) begin
      miscompares++;
      $display("FAIL score_saturation: score=%0d, required 255", score);
    end

    // Collision and food in the same verdict: respawns, then game over, then restart.
    k_coll = 100;
    run(120);

    // No verdicts: every check times out.
    k_coll = 0; k_ate = 0; k_valid = 0;
    run(60);

    // Long pause: no movement while waiting.
    k_valid = 100; k_pause = 100;
    run(25);
    k_pause = 0;

    // Reset in the middle of a check.
    k_valid = 0;
    for (int i = 0; i < 60 && m_ph != M_CHECK; i++) begin drive(); step(); end
    run(3);
    do_reset("mid-check");

    // Reset in the middle of a freeze.
    k_valid = 100; k_coll = 100;
    for (int i = 0; i < 200 && !(m_ph == M_FROZEN && frz_cnt >= 5); i++) begin drive(); step(); end
    do_reset("mid-freeze");

    // Random play with noise on the ignored inputs.
    k_start = 30; k_pause = 15; k_valid = 30; k_coll = 25; k_ate = 50; k_noise = 5;
    run(4000);

    k_start = 0; k_pause = 0; k_valid = 100; k_coll = 0; k_ate = 0; k_noise = 0;
    run(20);
    @(negedge clk);
    #1;
    vectors++;
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected events never seen, required 0", expq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/snake_step_controller.md
Name: snake_step_controller

Overview:
- Top-level game sequencer for the snake datapath.
- Divides the system clock into movement ticks. Each tick it issues a move pulse, then requests a collision check and waits for the verdict.
- On a collision it decrements lives, pulses respawn and holds the snake frozen for a few ticks. When lives reach zero it enters game-over.
- Sits between the snake position/body registers, the collision detection block and the VGA/score logic.

Parameters:
TICK_DIV, 5000000, clk cycles per movement tick (must be ≥ 2)
FREEZE_TICKS, 3, movement ticks the snake stays frozen after a respawn
INIT_LIVES, 3, lives loaded at start (1..7)
CHECK_TIMEOUT, 15, max cycles to wait for check_valid before abandoning the check

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  level; sampled in IDLE and OVER to begin a new game
pause  in  1  level; freezes the tick counter while high
check_valid  in  1  one-cycle strobe: collision verdict is valid
collision  in  1  collision verdict; qualified by check_valid
ate_food  in  1  qualified by check_valid; head landed on food
move_en  out  1  one-cycle pulse: advance the snake one block
check_req  out  1  one-cycle pulse: start a collision check
respawn  out  1  one-cycle pulse: reset snake length to 1 and place it at a new head position
grow  out  1  one-cycle pulse: lengthen the snake by one
lives  out  3  remaining lives
score  out  8  food eaten this game; saturates at 255
game_over  out  1  high while in OVER
state_dbg  out  3  encoded current state

Behaviour:
- Reset (async, any state, including mid-check): state = IDLE, tick counter = 0, freeze counter = 0, timeout counter = 0, lives = INIT_LIVES, score = 0, all pulse outputs = 0, game_over = 0.
- State encodings: IDLE = 0, WAIT = 1, MOVE = 2, CHECK = 3, RESPAWN = 4, FREEZE = 5, OVER = 6.
- IDLE
  - start = 1 → load lives = INIT_LIVES, clear score, clear tick counter, go to WAIT.
- WAIT
  - Tick counter increments each cycle while pause = 0 and holds while pause = 1.
  - When the counter reaches TICK_DIV-1: reset it to 0 and go to MOVE.
- MOVE
  - Lasts one cycle; move_en = 1. Next state is CHECK.
- CHECK
  - check_req = 1 on the first cycle in CHECK only; the timeout counter clears on entry.
  - check_valid & collision → go to RESPAWN. Collision has priority over ate_food in the same strobe, and no grow is issued.
  - check_valid & !collision & ate_food → grow = 1 in the next cycle (registered pulse), score += 1 (saturating), go to WAIT.
  - check_valid & !collision & !ate_food → go to WAIT.
  - No check_valid within CHECK_TIMEOUT cycles → go to WAIT with no side effects.
  - pause is ignored in MOVE and CHECK.
- RESPAWN
  - Lasts one cycle; lives decrements by 1.
  - If the lives value before the decrement is 1 → go to OVER and do not pulse respawn.
  - Otherwise → respawn = 1, freeze counter = 0, tick counter = 0, go to FREEZE.
- FREEZE
  - The tick counter runs as in WAIT (pause honoured). Each tick wrap increments the freeze counter.
  - When the freeze counter reaches FREEZE_TICKS → go to WAIT. No move_en is issued during FREEZE.
- OVER
  - game_over = 1; lives = 0; score holds.
  - start = 1 → behave as start in IDLE.
- Pulse outputs are registered and never assert for more than one cycle per event.
- lives never underflows; score never wraps.
- Latency:
  - tick wrap → move_en: 1 cycle.
  - move_en → check_req: 1 cycle.
  - check_valid → grow: 1 cycle.
  - collision check_valid → respawn: 1 cycle (RESPAWN state).
- An unreachable state encoding returns to IDLE.

Decomposition:
- Shared package/header holds the state encodings, the LIVES_WIDTH = 3 and SCORE_WIDTH = 8 constants, and default TICK_DIV.
- One sub-module, tick_divider: parameterised TICK_DIV counter with enable (not paused, state ∈ {WAIT, FREEZE}) and synchronous clear; outputs a one-cycle tick strobe.
- The FSM, lives/score registers and freeze counter stay in the top module.

Test Plan:
- TICK_DIV = 4; reset, start = 1 for 1 cycle → WAIT; move_en at cycle 5 after start, then check_req on the next cycle. Return check_valid = 1, collision = 0 → back to WAIT; the next move_en comes 4 cycles later.
- check_valid with collision = 0, ate_food = 1 → grow pulses exactly once, 1 cycle later; score 0 → 1. Repeat from score 255 → score stays 255.
- Collision with INIT_LIVES = 3 → lives 3 → 2 and respawn pulse. No move_en for FREEZE_TICKS × TICK_DIV = 12 cycles, then normal moves resume.
- Three collisions → third gives lives = 0, game_over = 1, no respawn pulse. start = 1 → lives = 3, score = 0, game_over = 0.
- collision = 1 and ate_food = 1 in the same strobe → respawn path taken, no grow, score unchanged. No check_valid for 15 cycles → return to WAIT with lives unchanged.
- Assert reset mid-CHECK and mid-FREEZE → next cycle state_dbg = 0, lives = 3, all pulses 0. pause = 1 in WAIT holds the counter, with no move_en for 20 cycles.
